conv_ctrl: RTL and testbench

CONV_CTRL -- requirements
Module: conv_ctrl

---
 rtl/conv_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_conv_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl.sv
// ---------------------------------------------------------------------------
// conv_ctrl
//
// Control block for a convolution datapath. It produces the periodic sample
// strobe, accepts kernel coefficients over a valid/ready stream into a shadow
// buffer, and commits the shadow buffer to the active kernel only on a sample
// strobe, so the datapath never sees a half-updated kernel. It also
// synchronizes the effect pushbutton and produces a one-cycle toggle pulse
// on each press.
//
// Optional feature:
//   CONV_CTRL_DEBOUNCE_EN  - when defined, a new button level is accepted
//                            only after it has been stable for
//                            DEBOUNCE_CYCLES consecutive clocks. When it is
//                            undefined, the synchronized level is used
//                            directly.
//
// Parameters:
//   DEPTH           - kernel taps per load
//   CLK_DIV         - clocks per sample period (>= 4)
//   DEBOUNCE_CYCLES - button stable time in clocks
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset_n    in   asynchronous active-low reset
//   coef_valid in   coefficient beat valid
//   coef_data  in   12-bit coefficient value
//   coef_last  in   final beat of a kernel load
//   coef_ready out  beat accepted when coef_valid & coef_ready
//   btn_n      in   asynchronous active-low effect pushbutton
//   kernel     out  active kernel, tap i at bits [i*12 +: 12]
//   update     out  one-cycle sample strobe
//   toggle_en  out  one-cycle effect-toggle pulse
//   busy       out  high whenever the load FSM is not idle
//   load_err   out  one-cycle pulse on a full load without coef_last
// ---------------------------------------------------------------------------
module conv_ctrl #(
    parameter int DEPTH           = 8,
    parameter int CLK_DIV         = 1024,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  coef_valid,
    input  logic [11:0]           coef_data,
    input  logic                  coef_last,
    output logic                  coef_ready,
    input  logic                  btn_n,
    output logic [DEPTH*12-1:0]   kernel,
    output logic                  update,
    output logic                  toggle_en,
    output logic                  busy,
    output logic                  load_err
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    // Reject parameter values that would break the counter or index logic.
    if (CLK_DIV < 4 || DEPTH < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("conv_ctrl: illegal parameter value");
    end

    state_t                      state;
    state_t                      state_next;
    logic [CNT_W-1:0]            sample_cnt;
    logic [IDX_W-1:0]            index;
    logic [DEPTH-1:0][11:0]      shadow;
    logic [DEPTH-1:0][11:0]      kernel_q;
    logic                        accept;
    logic                        btn_sync1;
    logic                        btn_sync2;
    logic                        btn_level;
    logic                        btn_prev;

    // -----------------------------------------------------------------------
    // Sample period counter; update is decoded from the terminal count so it
    // is high for exactly one cycle per period.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_cnt <= '0;
        end else if (sample_cnt == CNT_MAX) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    assign update = (sample_cnt == CNT_MAX);

    // -----------------------------------------------------------------------
    // Load FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Load FSM: next-state logic. A load that completes on an update edge
    // lands in PEND after that edge, so it naturally waits a full period.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (coef_last || DEPTH == 1) ? PEND : LOAD;
                end
            end
            LOAD: begin
                if (accept && (coef_last || index == IDX_LAST)) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (update) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Load FSM: outputs decoded from state only
    // -----------------------------------------------------------------------
    always_comb begin
        coef_ready = (state != PEND);
        busy       = (state != IDLE);
    end

    assign accept = coef_valid & coef_ready;

    // -----------------------------------------------------------------------
    // Shadow buffer, tap index, active kernel and load error pulse.
    // The first beat clears the whole shadow so taps not written by a short
    // load read as zero. The index checked for the full-load condition is
    // the one being written, i.e. the DEPTH-th beat writes tap DEPTH-1.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index       <= '0;
            shadow      <= '0;
            kernel_q    <= '0;
            kernel_q[0] <= 12'h7FF;
            load_err    <= 1'b0;
        end else begin
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shadow    <= '0;
                        shadow[0] <= coef_data;
                        index     <= IDX_W'(1);
                        load_err  <= (DEPTH == 1) && !coef_last;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shadow[index] <= coef_data;
                        index         <= index + IDX_W'(1);
                        load_err      <= (index == IDX_LAST) && !coef_last;
                    end
                end
                PEND: begin
                    if (update) begin
                        kernel_q <= shadow;
                        index    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign kernel = kernel_q;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous pushbutton, idle released.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync1 <= 1'b1;
            btn_sync2 <= 1'b1;
        end else begin
            btn_sync1 <= btn_n;
            btn_sync2 <= btn_sync1;
        end
    end

`ifdef CONV_CTRL_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt;

    // Counts consecutive clocks on which the synchronized level differs from
    // the accepted level; any return to the accepted level restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_level <= 1'b1;
            db_cnt    <= '0;
        end else if (btn_sync2 == btn_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
            btn_level <= btn_sync2;
            db_cnt    <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end
`else
    assign btn_level = btn_sync2;
`endif

    // -----------------------------------------------------------------------
    // Falling edge of the accepted button level gives one toggle pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev  <= 1'b1;
            toggle_en <= 1'b0;
        end else begin
            btn_prev  <= btn_level;
            toggle_en <= btn_prev & ~btn_level;
        end
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_ctrl
//
// Directed self-checking bench for conv_ctrl with DEPTH=8, CLK_DIV=8 and
// DEBOUNCE_CYCLES=16. Inputs are driven and outputs sampled 1 time unit after
// each rising clock edge.
// ---------------------------------------------------------------------------
module tb_conv_ctrl;

    localparam int DEPTH   = 8;
    localparam int CLK_DIV = 8;
    localparam int DEB     = 16;
    localparam int KW      = DEPTH * 12;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          coef_valid = 1'b0;
    logic [11:0]   coef_data  = 12'h000;
    logic          coef_last  = 1'b0;
    logic          btn_n      = 1'b1;
    logic          coef_ready;
    logic [KW-1:0] kernel;
    logic          update;
    logic          toggle_en;
    logic          busy;
    logic          load_err;

    int checks = 0;
    int errors = 0;

    logic [KW-1:0] ident_k;
    logic [KW-1:0] cur_k;

    int unsigned edges;

    conv_ctrl #(
        .DEPTH           (DEPTH),
        .CLK_DIV         (CLK_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_last  (coef_last),
        .coef_ready (coef_ready),
        .btn_n      (btn_n),
        .kernel     (kernel),
        .update     (update),
        .toggle_en  (toggle_en),
        .busy       (busy),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // Rising edges since the last reset release; the sample phase follows it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    function automatic bit exp_update();
        return (edges % CLK_DIV) == (CLK_DIV - 1);
    endfunction

    // Kernel with taps 0..n-1 = base, base+1, ... and the rest zero.
    function automatic logic [KW-1:0] k_seq(input int base, input int n);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k[i*12 +: 12] = 12'(base + i);
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [11:0] data, input logic last);
        coef_valid = 1'b1;
        coef_data  = data;
        coef_last  = last;
        tick();
        coef_valid = 1'b0;
        coef_last  = 1'b0;
    endtask

    task automatic align_to(input int phase);
        bit found;
        found = 0;
        for (int i = 0; i < 2 * CLK_DIV && !found; i++) begin
            if ((edges % CLK_DIV) == phase) found = 1;
            else tick();
        end
        if (!found) begin
            checks++; errors++;
            $display("[TB] FAIL align_timeout: phase %0d not reached", phase);
        end
    endtask

    // Kernel must hold old_k until the edge on which update is high, then
    // show new_k one cycle later with the FSM back in IDLE.
    task automatic wait_commit(input logic [KW-1:0] old_k, input logic [KW-1:0] new_k,
                               input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 3 * CLK_DIV && !done; i++) begin
            if (exp_update()) begin
                checks++;
                if (update !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s_update: got %b expected 1", name, update);
                end
                checks++;
                if (kernel !== old_k) begin
                    errors++;
                    $display("[TB] FAIL %s_precommit: got %h expected %h", name, kernel, old_k);
                end
                tick();
                checks++;
                if (kernel !== new_k) begin
                    errors++;
                    $display("[TB] FAIL %s_commit: got %h expected %h", name, kernel, new_k);
                end
                checks++;
                if (busy !== 1'b0 || coef_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s_idle: got busy=%b ready=%b expected busy=0 ready=1",
                             name, busy, coef_ready);
                end
                done = 1;
            end else begin
                checks++;
                if (kernel !== old_k || busy !== 1'b1 || load_err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s_hold: got kernel=%h busy=%b err=%b expected kernel=%h busy=1 err=0",
                             name, kernel, busy, load_err, old_k);
                end
                tick();
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL %s_timeout: no commit within %0d cycles", name, 3 * CLK_DIV);
        end
    endtask

    task automatic test_reset();
        logic exp_u;
        $display("[TB] test_reset");
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (kernel !== ident_k) begin
            errors++;
            $display("[TB] FAIL reset_kernel: got %h expected %h", kernel, ident_k);
        end
        checks++;
        if (busy !== 1'b0 || coef_ready !== 1'b1 || update !== 1'b0 ||
            load_err !== 1'b0 || toggle_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b ready=%b upd=%b err=%b tog=%b expected 0 1 0 0 0",
                     busy, coef_ready, update, load_err, toggle_en);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 3 * CLK_DIV; k++) begin
            tick();
            exp_u = ((k % CLK_DIV) == CLK_DIV - 1);
            checks++;
            if (update !== exp_u) begin
                errors++;
                $display("[TB] FAIL update_edge%0d: got %b expected %b", k, update, exp_u);
            end
        end
        cur_k = ident_k;
    endtask

    task automatic test_full_load();
        $display("[TB] test_full_load");
        for (int i = 0; i < DEPTH; i++) begin
            send_beat(12'(i + 1), i == DEPTH - 1);
            checks++;
            if (load_err !== 1'b0 || busy !== 1'b1 || kernel !== cur_k) begin
                errors++;
                $display("[TB] FAIL full_beat%0d: got err=%b busy=%b kernel=%h expected err=0 busy=1 kernel=%h",
                         i, load_err, busy, kernel, cur_k);
            end
        end
        checks++;
        if (coef_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_pend_ready: got %b expected 0", coef_ready);
        end
        wait_commit(cur_k, k_seq(1, 8), "full");
        cur_k = k_seq(1, 8);
    endtask

    task automatic test_short_load();
        $display("[TB] test_short_load");
        send_beat(12'h005, 1'b0);
        send_beat(12'h006, 1'b0);
        send_beat(12'h007, 1'b1);
        checks++;
        if (busy !== 1'b1 || coef_ready !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_pend: got busy=%b ready=%b err=%b expected 1 0 0",
                     busy, coef_ready, load_err);
        end
        wait_commit(cur_k, k_seq(5, 3), "short");
        cur_k = k_seq(5, 3);
    endtask

    task automatic test_load_err();
        logic exp_e;
        $display("[TB] test_load_err");
        align_to(0);
        for (int i = 0; i < DEPTH; i++) begin
            send_beat(12'(12'h101 + i), 1'b0);
            exp_e = (i == DEPTH - 1);
            checks++;
            if (load_err !== exp_e) begin
                errors++;
                $display("[TB] FAIL err_beat%0d: got %b expected %b", i, load_err, exp_e);
            end
        end
        checks++;
        if (coef_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_pend: got ready=%b busy=%b expected 0 1", coef_ready, busy);
        end
        send_beat(12'hABC, 1'b1);
        checks++;
        if (load_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_pulse_end: got err=%b busy=%b expected 0 1", load_err, busy);
        end
        wait_commit(cur_k, k_seq(12'h101, 8), "err");
        cur_k = k_seq(12'h101, 8);
    endtask

    task automatic test_same_edge();
        $display("[TB] test_same_edge");
        align_to(CLK_DIV - 1);
        checks++;
        if (update !== 1'b1) begin
            errors++;
            $display("[TB] FAIL same_update: got %b expected 1", update);
        end
        send_beat(12'h3C5, 1'b1);
        checks++;
        if (kernel !== cur_k || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL same_nocommit: got kernel=%h busy=%b expected kernel=%h busy=1",
                     kernel, busy, cur_k);
        end
        wait_commit(cur_k, k_seq(12'h3C5, 1), "same");
        cur_k = k_seq(12'h3C5, 1);
    endtask

    task automatic test_reset_mid_load();
        logic exp_u;
        $display("[TB] test_reset_mid_load");
        for (int i = 0; i < 4; i++) send_beat(12'(12'h011 + i), 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_busy: got %b expected 1", busy);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if (kernel !== ident_k || busy !== 1'b0 || coef_ready !== 1'b1 || update !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got kernel=%h busy=%b ready=%b upd=%b expected %h 0 1 0",
                     kernel, busy, coef_ready, update, ident_k);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= CLK_DIV; k++) begin
            tick();
            exp_u = (k == CLK_DIV - 1);
            checks++;
            if (update !== exp_u || busy !== 1'b0 || kernel !== ident_k) begin
                errors++;
                $display("[TB] FAIL mid_after%0d: got upd=%b busy=%b kernel=%h expected upd=%b busy=0 kernel=%h",
                         k, update, busy, kernel, exp_u, ident_k);
            end
        end
        cur_k = ident_k;
    endtask

    task automatic test_button();
        int pulses;
        int first;
        $display("[TB] test_button");
`ifdef CONV_CTRL_DEBOUNCE_EN
        pulses = 0;
        btn_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (toggle_en === 1'b1) pulses++;
        end
        btn_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (toggle_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL glitch_pulses: got %0d expected 0", pulses);
        end
        pulses = 0;
        first  = -1;
        btn_n  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (toggle_en === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        btn_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (toggle_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL press_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (first !== DEB + 3) begin
            errors++;
            $display("[TB] FAIL press_latency: got %0d expected %0d", first, DEB + 3);
        end
`else
        pulses = 0;
        first  = -1;
        btn_n  = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (toggle_en === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("[TB] FAIL press_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (first !== 3) begin
            errors++;
            $display("[TB] FAIL press_latency: got %0d expected 3", first);
        end
        pulses = 0;
        btn_n  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (toggle_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL release_pulses: got %0d expected 0", pulses);
        end
`endif
    endtask

    initial begin
        ident_k        = '0;
        ident_k[11:0]  = 12'h7FF;
        cur_k          = ident_k;
        test_reset();
        test_full_load();
        test_short_load();
        test_load_err();
        test_same_edge();
        test_reset_mid_load();
        test_button();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
